load_store_unit: RTL and testbench

RV64I load/store unit sitting between the execute stage and the byte-addressed 64 KiB data memory. It accepts one memory request at a time over a valid/ready handshake and drives the memory's byte write mask, 16-bit address and write data. For loads it captures the memory's combinational 64-bit read port and sign- or zero-extends the result per funct3. It returns a registered response, including a fault flag, over a second valid/ready handshake.

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 110 +++++++++++
 tb/tb_load_store_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The master side is the execute stage plus memory; the slave side is the unit.
interface load_store_unit_if #(
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_data;
  logic [4:0]        resp_rd;
  logic              resp_fault;
  logic [7:0]        mem_w_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_write_data;
  logic [63:0]       mem_read_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_fault,
    input  mem_w_mask, mem_address, mem_write_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_data, resp_rd, resp_fault,
    output mem_w_mask, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV64I load/store unit: one request at a time, single-cycle memory access,
// sign/zero-extended load data and a fault flag returned as a registered response.
module load_store_unit #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [4:0]  rd_q;
  logic [63:0] resp_data_q;
  logic [4:0]  resp_rd_q;
  logic        resp_fault_q;

  logic        out_of_range;
  logic        bad_funct3;
  logic        misaligned;
  logic        fault;
  logic [7:0]  store_mask;
  logic [63:0] load_data;

  // All checks work on the latched request, so they are stable for the whole ACCESS cycle.
  always_comb begin
    out_of_range = |addr_q[63:ADDR_W];
    bad_funct3   = we_q ? funct3_q[2] : (funct3_q == 3'b111);
    misaligned   = 1'b0;
    store_mask   = 8'h00;
    load_data    = 64'd0;
    case (funct3_q[1:0])
      2'b00:   store_mask = 8'h01;
      2'b01:   begin store_mask = 8'h03; misaligned = addr_q[0]; end
      2'b10:   begin store_mask = 8'h0F; misaligned = |addr_q[1:0]; end
      default: begin store_mask = 8'hFF; misaligned = |addr_q[2:0]; end
    endcase
    case (funct3_q)
      3'b000:  load_data = {{56{bus.mem_read_data[7]}},  bus.mem_read_data[7:0]};
      3'b001:  load_data = {{48{bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
      3'b010:  load_data = {{32{bus.mem_read_data[31]}}, bus.mem_read_data[31:0]};
      3'b011:  load_data = bus.mem_read_data;
      3'b100:  load_data = {56'd0, bus.mem_read_data[7:0]};
      3'b101:  load_data = {48'd0, bus.mem_read_data[15:0]};
      3'b110:  load_data = {32'd0, bus.mem_read_data[31:0]};
      default: load_data = 64'd0;
    endcase
    fault = out_of_range | bad_funct3 | misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 64'd0;
      wdata_q      <= 64'd0;
      rd_q         <= 5'd0;
      resp_data_q  <= 64'd0;
      resp_rd_q    <= 5'd0;
      resp_fault_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rd_q     <= bus.req_rd;
      end
      if (state == ACCESS) begin
        resp_rd_q    <= rd_q;
        resp_fault_q <= fault;
        resp_data_q  <= (fault || we_q) ? 64'd0 : load_data;
      end
    end
  end

  // Mask is decoded from the state register, so an async reset in ACCESS kills the write at once.
  assign bus.mem_w_mask     = (state == ACCESS && we_q && !fault) ? store_mask : 8'h00;
  assign bus.mem_address    = addr_q[ADDR_W-1:0];
  assign bus.mem_write_data = wdata_q;
  assign bus.req_ready      = (state == IDLE) && rst_n;
  assign bus.resp_valid     = (state == RESP);
  assign bus.resp_data      = resp_data_q;
  assign bus.resp_rd        = resp_rd_q;
  assign bus.resp_fault     = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model and a response scoreboard.
module tb_load_store_unit;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   mask_cycles = 0;
  logic [7:0] last_mask = 8'h00;
  logic [7:0] mem [0:65535];
  exp_t sb_q [$];

  load_store_unit_if #(.ADDR_W(16)) lsu ();

  load_store_unit #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (lsu.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (lsu.mem_w_mask[i]) mem[lsu.mem_address + 16'(i)] <= lsu.mem_write_data[8*i +: 8];
    end
  end

  always_comb begin
    lsu.mem_read_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      lsu.mem_read_data[8*i +: 8] = mem[lsu.mem_address + 16'(i)];
    end
  end

  always @(negedge clk) begin
    if (lsu.mem_w_mask != 8'h00) begin
      mask_cycles = mask_cycles + 1;
      last_mask   = lsu.mem_w_mask;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [4:0] rd,
                                input logic [63:0] exp_data, input logic exp_fault);
    int n = 0;
    sb_q.push_back('{data: exp_data, rd: rd, fault: exp_fault});
    @(negedge clk);
    while (!lsu.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("req_ready_wait", 64'(lsu.req_ready), 64'd1);
    lsu.req_valid  = 1'b1;
    lsu.req_we     = we;
    lsu.req_funct3 = f3;
    lsu.req_addr   = addr;
    lsu.req_wdata  = wdata;
    lsu.req_rd     = rd;
    @(posedge clk);
    #1 lsu.req_valid = 1'b0;
  endtask

  task automatic pop_compare();
    exp_t e;
    check_val("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val("resp_data", lsu.resp_data, e.data);
      check_val("resp_rd", 64'(lsu.resp_rd), 64'(e.rd));
      check_val("resp_fault", 64'(lsu.resp_fault), 64'(e.fault));
    end
  endtask

  task automatic check_output();
    int n = 0;
    @(negedge clk);
    while (!lsu.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("resp_valid_timeout", 64'(lsu.resp_valid), 64'd1);
    pop_compare();
    lsu.resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mc0;
    int n;
    int cyc;
    int sent;
    int got;
    logic acc;
    logic [63:0] held_data;
    int times [4];
    logic [2:0]  tp_f3   [4];
    logic [63:0] tp_addr [4];
    logic [63:0] tp_exp  [4];

    rst_n          = 1'b0;
    lsu.req_valid  = 1'b0;
    lsu.req_we     = 1'b0;
    lsu.req_funct3 = 3'd0;
    lsu.req_addr   = 64'd0;
    lsu.req_wdata  = 64'd0;
    lsu.req_rd     = 5'd0;
    lsu.resp_ready = 1'b1;

    #3;
    check_val("rst_req_ready", 64'(lsu.req_ready), 64'd0);
    check_val("rst_resp_valid", 64'(lsu.resp_valid), 64'd0);
    check_val("rst_mask", 64'(lsu.mem_w_mask), 64'd0);
    check_val("rst_mem_address", 64'(lsu.mem_address), 64'd0);
    check_val("rst_resp_data", lsu.resp_data, 64'd0);
    check_val("rst_resp_rd", 64'(lsu.resp_rd), 64'd0);
    check_val("rst_resp_fault", 64'(lsu.resp_fault), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_req_ready", 64'(lsu.req_ready), 64'd1);

    $display("[TB] store then load");
    mc0 = mask_cycles;
    apply_stimulus(1'b1, 3'b011, 64'h0100, 64'h1122334455667788, 5'd1, 64'd0, 1'b0);
    check_output();
    check_val("sd_mask_cycles", 64'(mask_cycles - mc0), 64'd1);
    check_val("sd_mask", 64'(last_mask), 64'hFF);
    apply_stimulus(1'b0, 3'b011, 64'h0100, 64'd0, 5'd2, 64'h1122334455667788, 1'b0);
    check_output();

    $display("[TB] sign and zero extension");
    apply_stimulus(1'b1, 3'b000, 64'h0200, 64'hFFFFFFFFFFFFFF80, 5'd3, 64'd0, 1'b0);
    check_output();
    check_val("sb_mask", 64'(last_mask), 64'h01);
    apply_stimulus(1'b0, 3'b000, 64'h0200, 64'd0, 5'd4, 64'hFFFFFFFFFFFFFF80, 1'b0);
    check_output();
    apply_stimulus(1'b0, 3'b100, 64'h0200, 64'd0, 5'd5, 64'h0000000000000080, 1'b0);
    check_output();
    apply_stimulus(1'b1, 3'b010, 64'h0204, 64'h0000000080000000, 5'd6, 64'd0, 1'b0);
    check_output();
    check_val("sw_mask", 64'(last_mask), 64'h0F);
    apply_stimulus(1'b0, 3'b010, 64'h0204, 64'd0, 5'd7, 64'hFFFFFFFF80000000, 1'b0);
    check_output();
    apply_stimulus(1'b0, 3'b110, 64'h0204, 64'd0, 5'd8, 64'h0000000080000000, 1'b0);
    check_output();
    apply_stimulus(1'b0, 3'b001, 64'h0206, 64'd0, 5'd9, 64'hFFFFFFFFFFFF8000, 1'b0);
    check_output();
    apply_stimulus(1'b0, 3'b101, 64'h0206, 64'd0, 5'd10, 64'h0000000000008000, 1'b0);
    check_output();
    apply_stimulus(1'b1, 3'b001, 64'h0208, 64'h000000000000BEEF, 5'd11, 64'd0, 1'b0);
    check_output();
    check_val("sh_mask", 64'(last_mask), 64'h03);

    $display("[TB] faults");
    mc0 = mask_cycles;
    apply_stimulus(1'b1, 3'b001, 64'h0101, 64'hFFFFFFFFFFFFFFFF, 5'd12, 64'd0, 1'b1);
    check_output();
    apply_stimulus(1'b0, 3'b010, 64'h0102, 64'd0, 5'd13, 64'd0, 1'b1);
    check_output();
    apply_stimulus(1'b0, 3'b011, 64'h0000000000010000, 64'd0, 5'd14, 64'd0, 1'b1);
    check_output();
    apply_stimulus(1'b0, 3'b111, 64'h0100, 64'd0, 5'd15, 64'd0, 1'b1);
    check_output();
    apply_stimulus(1'b1, 3'b100, 64'h0100, 64'hFFFFFFFFFFFFFFFF, 5'd16, 64'd0, 1'b1);
    check_output();
    check_val("fault_mask_cycles", 64'(mask_cycles - mc0), 64'd0);
    apply_stimulus(1'b0, 3'b011, 64'h0100, 64'd0, 5'd17, 64'h1122334455667788, 1'b0);
    check_output();

    $display("[TB] back-pressure");
    lsu.resp_ready = 1'b0;
    apply_stimulus(1'b0, 3'b011, 64'h0100, 64'd0, 5'd18, 64'h1122334455667788, 1'b0);
    lsu.req_valid  = 1'b1;
    lsu.req_we     = 1'b0;
    lsu.req_funct3 = 3'b100;
    lsu.req_addr   = 64'h0200;
    lsu.req_rd     = 5'd19;
    n = 0;
    @(negedge clk);
    while (!lsu.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("bp_resp_valid_timeout", 64'(lsu.resp_valid), 64'd1);
    pop_compare();
    held_data = lsu.resp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_resp_valid_held", 64'(lsu.resp_valid), 64'd1);
      check_val("bp_resp_data_held", lsu.resp_data, held_data);
      check_val("bp_resp_rd_held", 64'(lsu.resp_rd), 64'd18);
      check_val("bp_req_ready_low", 64'(lsu.req_ready), 64'd0);
    end
    lsu.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("bp_idle_req_ready", 64'(lsu.req_ready), 64'd1);
    check_val("bp_idle_resp_valid", 64'(lsu.resp_valid), 64'd0);
    @(posedge clk);
    #1 lsu.req_valid = 1'b0;
    sb_q.push_back('{data: 64'h80, rd: 5'd19, fault: 1'b0});
    @(negedge clk);
    check_val("bp_second_accepted", 64'(lsu.req_ready), 64'd0);
    check_output();

    $display("[TB] throughput");
    tp_f3[0] = 3'b011; tp_addr[0] = 64'h0100; tp_exp[0] = 64'h1122334455667788;
    tp_f3[1] = 3'b110; tp_addr[1] = 64'h0204; tp_exp[1] = 64'h0000000080000000;
    tp_f3[2] = 3'b000; tp_addr[2] = 64'h0200; tp_exp[2] = 64'hFFFFFFFFFFFFFF80;
    tp_f3[3] = 3'b010; tp_addr[3] = 64'h0204; tp_exp[3] = 64'hFFFFFFFF80000000;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{data: tp_exp[i], rd: 5'(20 + i), fault: 1'b0});
      times[i] = 0;
    end
    lsu.resp_ready = 1'b1;
    lsu.req_valid  = 1'b1;
    lsu.req_we     = 1'b0;
    lsu.req_funct3 = tp_f3[0];
    lsu.req_addr   = tp_addr[0];
    lsu.req_rd     = 5'd20;
    cyc  = 0;
    sent = 0;
    got  = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (lsu.resp_valid) begin
        pop_compare();
        times[got] = cyc;
        got++;
      end
      acc = lsu.req_ready & lsu.req_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent == 4) begin
          lsu.req_valid = 1'b0;
        end else begin
          lsu.req_funct3 = tp_f3[sent];
          lsu.req_addr   = tp_addr[sent];
          lsu.req_rd     = 5'(20 + sent);
        end
      end
    end
    lsu.req_valid = 1'b0;
    check_val("tp_responses", 64'(got), 64'd4);
    for (int i = 0; i < 3; i++) begin
      check_val("tp_spacing", 64'(times[i+1] - times[i]), 64'd3);
    end

    $display("[TB] reset mid-store");
    apply_stimulus(1'b1, 3'b011, 64'h0300, 64'h0123456789ABCDEF, 5'd24, 64'd0, 1'b0);
    check_output();
    @(negedge clk);
    lsu.req_valid  = 1'b1;
    lsu.req_we     = 1'b1;
    lsu.req_funct3 = 3'b011;
    lsu.req_addr   = 64'h0300;
    lsu.req_wdata  = 64'hAAAAAAAAAAAAAAAA;
    lsu.req_rd     = 5'd25;
    @(posedge clk);
    #1 lsu.req_valid = 1'b0;
    check_val("rs_mask_in_access", 64'(lsu.mem_w_mask), 64'hFF);
    #2 rst_n = 1'b0;
    #1;
    check_val("rs_mask_dropped", 64'(lsu.mem_w_mask), 64'd0);
    check_val("rs_resp_valid", 64'(lsu.resp_valid), 64'd0);
    check_val("rs_req_ready", 64'(lsu.req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rs_post_req_ready", 64'(lsu.req_ready), 64'd1);
    check_val("rs_post_resp_valid", 64'(lsu.resp_valid), 64'd0);
    apply_stimulus(1'b0, 3'b011, 64'h0300, 64'd0, 5'd26, 64'h0123456789ABCDEF, 1'b0);
    check_output();

    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
